// File: rtl/ela_pkg.sv
// Shared ELA types and geometry.
// Used by the field source, the ELA core and benches.
package ela_pkg;

  localparam int IMG_W    = 128;
  localparam int FLD_ROWS = 32;
  localparam int PIX_W    = 8;
  localparam int ADDR_W   = 12;
  localparam int COL_W    = 7;
  localparam int ROW_W    = 5;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(FLD_ROWS - 1);

  typedef logic [PIX_W-1:0] pix_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRIME,
    S_PRIMED,
    S_STREAM,
    S_WAIT,
    S_DONE
  } ela_src_state_t;

endpackage

// File: rtl/ela_src_prefetch.sv
// Two-entry pixel buffer between field memory
// return data and the registered in_data stage.
module ela_src_prefetch
  import ela_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [PIX_W-1:0] din,
  output logic [PIX_W-1:0] head,
  output logic [1:0]       occ
);

  logic [PIX_W-1:0] slot0;
  logic [PIX_W-1:0] slot1;
  logic [1:0]       cnt;

  // Shift-style buffer: slot0 is always the oldest pixel.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot0 <= '0;
      slot1 <= '0;
      cnt   <= '0;
    end else if (flush) begin
      cnt <= '0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (cnt == 2'd0) slot0 <= din;
          else             slot1 <= din;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          slot0 <= slot1;
          cnt   <= cnt - 2'd1;
        end
        2'b11: begin
          if (cnt == 2'd1) begin
            slot0 <= din;
          end else begin
            slot0 <= slot1;
            slot1 <= din;
          end
        end
        default: ;
      endcase
    end
  end

  assign head = slot0;
  assign occ  = cnt;

endmodule

// File: rtl/ela_field_source.sv
// Field-memory responder feeding the ELA core row by row.
// ELA_SRC_CHKSUM_EN adds a 16-bit sum of delivered pixels.
module ela_field_source
  import ela_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              req,
  output logic              ready,
  output logic [PIX_W-1:0]  in_data,
  output logic              fld_rd,
  output logic [ADDR_W-1:0] fld_addr,
  input  logic [PIX_W-1:0]  fld_data,
  output logic              src_done,
  output logic              err
`ifdef ELA_SRC_CHKSUM_EN
  ,
  output logic [15:0]       chksum
`endif
);

  ela_src_state_t state_q, state_d;

  logic [ROW_W-1:0]  row_q;
  logic [COL_W-1:0]  col_q;
  logic [ADDR_W:0]   rd_ptr_q;
  logic              rd_q;
  logic [1:0]        occ;
  logic [PIX_W-1:0]  head;
  logic [PIX_W-1:0]  nxt_pix;
  logic [2:0]        fill;
  logic              go, acc, adv;
  logic              row_end, to_done;
  logic              push, pop, active, bad_req;

  ela_src_prefetch u_pf (
    .clk  (clk),
    .rst  (rst),
    .flush(go),
    .push (push),
    .pop  (pop),
    .din  (fld_data),
    .head (head),
    .occ  (occ)
  );

  // Next state and per-cycle advance decisions.
  always_comb begin
    state_d = state_q;
    acc     = 1'b0;
    adv     = 1'b0;
    row_end = 1'b0;
    to_done = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) state_d = S_PRIME;
      end
      S_PRIME: begin
        if (rd_q) begin
          adv     = 1'b1;
          state_d = S_PRIMED;
        end
      end
      S_PRIMED, S_WAIT: begin
        if (req) begin
          acc     = 1'b1;
          adv     = 1'b1;
          state_d = S_STREAM;
        end
      end
      S_STREAM: begin
        if (col_q != COL_LAST) begin
          adv = 1'b1;
        end else if (row_q == ROW_LAST) begin
          to_done = 1'b1;
          state_d = S_DONE;
        end else begin
          adv     = 1'b1;
          row_end = 1'b1;
          state_d = S_WAIT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign go      = start &
                   ((state_q == S_IDLE) |
                    (state_q == S_DONE));
  assign active  = (state_q != S_IDLE) &
                   (state_q != S_DONE);
  assign bad_req = req &
                   (state_q != S_PRIMED) &
                   (state_q != S_WAIT);
  assign pop     = adv & (occ != 2'd0);
  assign push    = rd_q & ~(adv & (occ == 2'd0));
  assign nxt_pix = (occ != 2'd0) ? head : fld_data;
  assign fill    = {1'b0, occ} + {2'b0, push}
                 - {2'b0, pop};
  assign fld_rd  = active & ~rd_ptr_q[ADDR_W]
                 & (fill < 3'd2);
  assign fld_addr = fld_rd ? rd_ptr_q[ADDR_W-1:0]
                           : '0;
  assign ready   = (state_q == S_PRIMED);

  // State, read pointer, counters and flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      rd_ptr_q <= '0;
      rd_q     <= 1'b0;
      row_q    <= '0;
      col_q    <= '0;
      in_data  <= '0;
      src_done <= 1'b0;
      err      <= 1'b0;
    end else begin
      state_q <= state_d;
      rd_q    <= fld_rd;
      if (go)          rd_ptr_q <= '0;
      else if (fld_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (go) begin
        row_q <= '0;
        col_q <= '0;
      end else if (acc) begin
        col_q <= COL_W'(1);
      end else if (row_end) begin
        col_q <= '0;
        row_q <= row_q + 1'b1;
      end else if (adv && state_q == S_STREAM) begin
        col_q <= col_q + 1'b1;
      end
      if (to_done)  in_data <= '0;
      else if (adv) in_data <= nxt_pix;
      if (go)           src_done <= 1'b0;
      else if (to_done) src_done <= 1'b1;
      err <= go ? 1'b0 : (err | bad_req);
    end
  end

`ifdef ELA_SRC_CHKSUM_EN
  // Running sum of every pixel handed to the core.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      chksum <= '0;
    end else if (go) begin
      chksum <= '0;
    end else if (acc || state_q == S_STREAM) begin
      chksum <= chksum + {8'd0, in_data};
    end
  end
`endif

endmodule

// File: tb/tb_ela_field_source.sv
// Directed scoreboard bench for ela_field_source.
// Optional chksum checks under ELA_SRC_CHKSUM_EN.
module tb_ela_field_source;
  import ela_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic              req = 1'b0;
  logic              ready, fld_rd, src_done, err;
  logic [PIX_W-1:0]  in_data;
  logic [PIX_W-1:0]  fld_data = '0;
  logic [ADDR_W-1:0] fld_addr;
`ifdef ELA_SRC_CHKSUM_EN
  logic [15:0]       chksum;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int exp_addr = 0;
  int err_row = -1;
  int err_col = -1;
  logic hold = 1'b0;
  logic exp_err = 1'b0;
  logic [PIX_W-1:0] mem [4096];
  logic [PIX_W-1:0] q [$];

  ela_field_source dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .req     (req),
    .ready   (ready),
    .in_data (in_data),
    .fld_rd  (fld_rd),
    .fld_addr(fld_addr),
    .fld_data(fld_data),
    .src_done(src_done),
    .err     (err)
`ifdef ELA_SRC_CHKSUM_EN
    ,
    .chksum  (chksum)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  // Synchronous field memory, one-cycle latency.
  always @(posedge clk)
    if (fld_rd) fld_data <= mem[fld_addr];

  // Every issued read must be the next linear address.
  always @(posedge clk)
    if (rst && fld_rd) begin
      chk("rd_addr", 32'(fld_addr), 32'(exp_addr));
      exp_addr++;
    end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [PIX_W-1:0] pv(int r, int k);
    return mem[r * IMG_W + k];
  endfunction

  task automatic start_field;
    start = 1'b1;
    exp_addr = 0;
    tick();
    start = 1'b0;
    @(negedge clk);
    chk("c1_rd", 32'(fld_rd), 32'd1);
    chk("c1_addr", 32'(fld_addr), 32'd0);
    chk("c1_ready", 32'(ready), 32'd0);
    chk("c1_done", 32'(src_done), 32'd0);
    chk("c1_err", 32'(err), 32'd0);
    tick();
    @(negedge clk);
    chk("c2_rd", 32'(fld_rd), 32'd1);
    chk("c2_addr", 32'(fld_addr), 32'd1);
    chk("c2_ready", 32'(ready), 32'd0);
    tick();
  endtask

  task automatic stream_row(input int r);
    for (int k = 0; k < IMG_W; k++)
      q.push_back(pv(r, k));
    for (int k = 0; k < IMG_W; k++) begin
      @(negedge clk);
      if (k == 0) begin
        chk("req_ready", 32'(ready), 32'(r == 0));
        chk("row_err", 32'(err), 32'(exp_err));
      end
      if (k == 64)
        chk("mid_ready", 32'(ready), 32'd0);
      chk("pix", 32'(in_data), 32'(q.pop_front()));
      tick();
      req = hold | (err_col == k + 1);
    end
  endtask

  task automatic run_field(input int gap);
    int g;
    logic [15:0] sum;
    sum = '0;
    for (int a = 0; a < 4096; a++)
      sum = sum + 16'(mem[a]);
    for (int r = 0; r < FLD_ROWS; r++) begin
      req = 1'b1;
      err_col = (r == err_row) ? 40 : -1;
      stream_row(r);
      if (hold || r == err_row) exp_err = 1'b1;
      g = (r % 2 == 1) ? gap : 0;
      if (r < FLD_ROWS - 1)
        for (int i = 0; i < g; i++) begin
          @(negedge clk);
          if (i == g - 1) begin
            chk("hold_p0", 32'(in_data),
                32'(pv(r + 1, 0)));
            chk("wait_ready", 32'(ready), 32'd0);
          end
          tick();
        end
    end
    @(negedge clk);
    chk("done_pix", 32'(in_data), 32'd0);
    chk("done_flag", 32'(src_done), 32'd1);
    chk("done_ready", 32'(ready), 32'd0);
    chk("done_rd", 32'(fld_rd), 32'd0);
    chk("done_err", 32'(err), 32'(exp_err));
`ifdef ELA_SRC_CHKSUM_EN
    chk("chksum", 32'(chksum), 32'(sum));
`endif
    repeat (4) tick();
    chk("rd_count", 32'(exp_addr), 32'd4096);
    chk("done_sticky", 32'(src_done), 32'd1);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ready"}, 32'(ready), 32'd0);
    chk({tag, "_pix"}, 32'(in_data), 32'd0);
    chk({tag, "_rd"}, 32'(fld_rd), 32'd0);
    chk({tag, "_addr"}, 32'(fld_addr), 32'd0);
    chk({tag, "_done"}, 32'(src_done), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
  endtask

  initial begin
    for (int a = 0; a < 4096; a++)
      mem[a] = PIX_W'(a % 251);

    repeat (3) tick();
    @(negedge clk);
    chk_zero("reset");
    tick();
    rst = 1'b1;
    tick();

    // Gapped field with a stray req in row 2.
    hold = 1'b0;
    err_row = 2;
    exp_err = 1'b0;
    start_field();
    run_field(128);

    // Restart from DONE with req held high.
    hold = 1'b1;
    err_row = -1;
    exp_err = 1'b0;
    start_field();
    run_field(0);
    req = 1'b0;
    hold = 1'b0;
    tick();

    // Reset in the middle of row 10.
    exp_err = 1'b0;
    start_field();
    for (int r = 0; r < 10; r++) begin
      req = 1'b1;
      stream_row(r);
    end
    req = 1'b1;
    tick();
    req = 1'b0;
    repeat (59) tick();
    rst = 1'b0;
    q.delete();
    #1;
    chk_zero("midrst");
    tick();
    @(negedge clk);
    chk_zero("midrst_hold");
    tick();
    rst = 1'b1;
    tick();
    start_field();
    req = 1'b1;
    stream_row(0);
    req = 1'b0;
    tick();

`ifdef ELA_SRC_CHKSUM_EN
    // All-0xFF field for the checksum wrap.
    rst = 1'b0;
    tick();
    rst = 1'b1;
    for (int a = 0; a < 4096; a++)
      mem[a] = 8'hFF;
    tick();
    exp_err = 1'b0;
    start_field();
    run_field(0);
    chk("chksum_ff", 32'(chksum), 32'h0000_F000);
`endif

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
